// File: rtl/detect_58_sched.sv
// Round-robin time-shared detector for the serial pattern 8'd58 (0011_1010, MSB first) on NUM_CH streams.
// Optional per-channel saturating hit counters are built when DET_HIT_CNT_EN is defined.
module detect_58_sched #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [(1<<CH_W)-1:0]     bit_valid,
  input  logic [(1<<CH_W)-1:0]     bit_in,
  output logic [(1<<CH_W)-1:0]     bit_ready,
  input  logic [(1<<CH_W)-1:0]     ch_clr,
  output logic                     det_valid,
  output logic [CH_W-1:0]          det_ch,
  input  logic                     det_ready,
  input  logic [CH_W-1:0]          cnt_sel,
  output logic [CNT_W-1:0]         hit_cnt
);

  localparam int NUM_CH = 1 << CH_W;

  // Shared next-state unit; states 9..15 fall back to state-0 behaviour.
  function automatic logic [3:0] next_state(input logic [3:0] s, input logic b);
    logic [3:0] n;
    case (s)
      4'd0:    n = b ? 4'd0 : 4'd1;
      4'd1:    n = b ? 4'd0 : 4'd2;
      4'd2:    n = b ? 4'd3 : 4'd2;
      4'd3:    n = b ? 4'd4 : 4'd1;
      4'd4:    n = b ? 4'd5 : 4'd1;
      4'd5:    n = b ? 4'd0 : 4'd6;
      4'd6:    n = b ? 4'd7 : 4'd2;
      4'd7:    n = b ? 4'd0 : 4'd8;
      4'd8:    n = b ? 4'd0 : 4'd2;
      default: n = b ? 4'd0 : 4'd1;
    endcase
    return n;
  endfunction

  logic [NUM_CH-1:0][3:0] state_q, state_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic                   det_valid_q, det_valid_d;
  logic [CH_W-1:0]        det_ch_q, det_ch_d;

  logic [NUM_CH-1:0]      eligible_s;
  logic                   grant_en_s;
  logic                   found_s;
  logic [CH_W-1:0]        gidx_s;
  logic [CH_W-1:0]        idx_s;
  logic                   xfer_s;
  logic [3:0]             nxt_s;
  logic                   hit_s;

  assign eligible_s = bit_valid & ~ch_clr;
  // Gating with rst_n keeps bit_ready low throughout reset.
  assign grant_en_s = rst_n & (~det_valid_q | det_ready);

  // First eligible channel searching upward from the pointer, with wrap.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = ptr_q + CH_W'(k);
      if (!found_s && eligible_s[idx_s]) begin
        found_s = 1'b1;
        gidx_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign xfer_s    = grant_en_s & found_s;
  assign bit_ready = xfer_s ? (NUM_CH'(1) << gidx_s) : '0;
  assign nxt_s     = next_state(state_q[gidx_s], bit_in[gidx_s]);
  assign hit_s     = xfer_s & (nxt_s == 4'd8);

  // Next-state for channel states, pointer and the one-entry event slot.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    det_valid_d = det_valid_q;
    det_ch_d    = det_ch_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_clr[i]) begin
        state_d[i] = 4'd0;
      end else if (xfer_s && gidx_s == CH_W'(i)) begin
        state_d[i] = nxt_s;
      end else begin
        state_d[i] = state_q[i];
      end
    end
    if (xfer_s) begin
      ptr_d = gidx_s + CH_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
    // A fresh detection overrides the consumer's acceptance of the old one.
    if (hit_s) begin
      det_valid_d = 1'b1;
      det_ch_d    = gidx_s;
    end else if (det_valid_q && det_ready) begin
      det_valid_d = 1'b0;
    end else begin
      det_valid_d = det_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= '0;
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;

`ifdef DET_HIT_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-channel detection counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_clr[i]) begin
        cnt_d[i] = '0;
      end else if (hit_s && gidx_s == CH_W'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_cnt = cnt_q[cnt_sel];
`else
  logic unused_cnt_sel_s;
  assign unused_cnt_sel_s = ^cnt_sel;
  assign hit_cnt          = '0;
`endif

endmodule

// File: tb/tb_detect_58_sched.sv
// Bench for detect_58_sched: directed scenarios plus randomized traffic, checked every
// cycle against a history-based pattern model (longest suffix that is a pattern prefix).
module tb_detect_58_sched;
  localparam int CH_W  = 2;
  localparam int CNT_W = 8;
  localparam int N     = 1 << CH_W;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     bit_valid;
  logic [N-1:0]     bit_in;
  logic [N-1:0]     bit_ready;
  logic [N-1:0]     ch_clr;
  logic             det_valid;
  logic [CH_W-1:0]  det_ch;
  logic             det_ready;
  logic [CH_W-1:0]  cnt_sel;
  logic [CNT_W-1:0] hit_cnt;

  detect_58_sched #(.CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .ch_clr(ch_clr), .det_valid(det_valid),
    .det_ch(det_ch), .det_ready(det_ready), .cnt_sel(cnt_sel), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0]  pat_v = 8'd58;
  logic [14:0] ovl_v = 15'b001110100111010;

  // Model: last bits consumed per channel, how many since clear, and event slot.
  int m_hist [N];
  int m_n    [N];
  int m_cnt  [N];
  int m_ptr;
  int m_dv;
  int m_ch;

  task automatic check(input string nm, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d at t=%0t", nm, got, exp, $time);
  endtask

  function automatic int match_len(input int h, input int n);
    int r;
    r = 0;
    for (int l = 1; l <= 8; l++)
      if (l <= n && ((h & ((1 << l) - 1)) == (58 >> (8 - l)))) r = l;
    return r;
  endfunction

  function automatic int pick();
    int i;
    if (!rst_n) return -1;
    if (m_dv != 0 && !det_ready) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (bit_valid[i] && !ch_clr[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0;
    end
    m_ptr = 0; m_dv = 0; m_ch = 0;
  endtask

  // Per-cycle compare against the model, then advance it with the inputs the next edge sees.
  initial begin
    int g;
    int h;
    int exp_cnt;
    int hit;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      g = pick();
      check("bit_ready", int'(bit_ready), (g >= 0) ? (1 << g) : 0);
      check("det_valid", int'(det_valid), m_dv);
      check("det_ch", int'(det_ch), m_ch);
`ifdef DET_HIT_CNT_EN
      exp_cnt = m_cnt[cnt_sel];
`else
      exp_cnt = 0;
`endif
      check("hit_cnt", int'(hit_cnt), exp_cnt);
      if (rst_n) begin
        hit = 0;
        for (int i = 0; i < N; i++)
          if (ch_clr[i]) begin m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0; end
        if (g >= 0) begin
          h = ((m_hist[g] << 1) | int'(bit_in[g])) & 255;
          m_hist[g] = h;
          m_n[g] = (m_n[g] < 8) ? m_n[g] + 1 : 8;
          if (match_len(h, m_n[g]) == 8) hit = 1;
          m_ptr = (g + 1) % N;
        end
        if (hit != 0) begin
          m_dv = 1; m_ch = g;
          if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g] = m_cnt[g] + 1;
        end else if (m_dv != 0 && det_ready) begin
          m_dv = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pidx [N];

  initial begin
    // Hand-computed pins on the model's pattern rule.
    check("model_full", match_len(58, 8), 8);
    check("model_overlap", match_len(8'b10100, 8), 2);
    check("model_three", match_len(8'b001, 3), 3);

    rst_n = 1'b0; bit_valid = '0; bit_in = '0; ch_clr = '0;
    det_ready = 1'b1; cnt_sel = '0;
    tick(); tick();
    check("rst_det_valid", int'(det_valid), 0);
    check("rst_bit_ready", int'(bit_ready), 0);
    rst_n = 1'b1;

    // Single stream on channel 0.
    for (int k = 0; k < 8; k++) begin
      bit_valid = 4'b0001; bit_in = {3'b000, pat_v[7-k]};
      #1;
      check("single_ready", int'(bit_ready), 1);
      check("single_no_early", int'(det_valid), 0);
      tick();
    end
    check("single_det", int'(det_valid), 1);
    check("single_ch", int'(det_ch), 0);
    bit_valid = '0;
    tick();
    check("single_clear", int'(det_valid), 0);

    // Overlapping matches on channel 1.
    bit_valid = 4'b0010;
    for (int k = 0; k < 15; k++) begin
      bit_in = {2'b00, ovl_v[14-k], 1'b0};
      tick();
      check("overlap_det", int'(det_valid), (k == 7 || k == 14) ? 1 : 0);
      if (k == 14) check("overlap_ch", int'(det_ch), 1);
    end
    bit_valid = '0;

    // Round-robin with all channels valid; channel 2 carries the pattern.
    bit_valid = 4'b1111;
    for (int k = 0; k < 32; k++) begin
      bit_in = {1'b0, pat_v[7-(k/4)], 2'b00};
      #1;
      check("rr_grant", int'(bit_ready), 1 << ((2 + k) % 4));
      tick();
      if (k == 28) begin
        check("rr_det", int'(det_valid), 1);
        check("rr_ch", int'(det_ch), 2);
      end
    end

    // Backpressure: event held, grants stalled, then resume from saved pointer.
    bit_valid = '0; ch_clr = 4'b1111;
    tick();
    ch_clr = '0; det_ready = 1'b0; bit_valid = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      bit_in = {3'b000, pat_v[7-j]};
      tick();
    end
    bit_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      bit_in = 4'($urandom);
      #1;
      check("bp_ready", int'(bit_ready), 0);
      check("bp_hold", int'(det_valid), 1);
      tick();
    end
    det_ready = 1'b1;
    #1;
    check("bp_resume", int'(bit_ready), 2);
    tick();

    // Clear on channel 3 while at state 7.
    bit_valid = '0; ch_clr = 4'b1000;
    tick();
    ch_clr = '0; bit_valid = 4'b1000;
    for (int j = 0; j < 7; j++) begin
      bit_in = {pat_v[7-j], 3'b000};
      tick();
    end
    ch_clr = 4'b1000; bit_in = '0;
    #1;
    check("clr_mask", int'(bit_ready), 0);
    tick();
    ch_clr = '0;
    tick();
    check("clr_no_det", int'(det_valid), 0);
    cnt_sel = 2'd3;
    #1;
    check("clr_hit_cnt", int'(hit_cnt), 0);
    bit_valid = '0;
    tick();

    // Randomized traffic, bits mostly following each channel's pattern position.
    for (int i = 0; i < N; i++) pidx[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      bit_valid = 4'($urandom);
      for (int i = 0; i < N; i++)
        bit_in[i] = ($urandom_range(0, 7) != 0) ? pat_v[7 - pidx[i]] : 1'($urandom);
      ch_clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      det_ready = ($urandom_range(0, 3) != 0);
      cnt_sel = 2'($urandom);
      #1;
      for (int i = 0; i < N; i++)
        if (bit_ready[i]) pidx[i] = (pidx[i] + 1) % 8;
      tick();
    end

    // Async reset mid-stream with an event pending.
    bit_valid = '0; ch_clr = 4'b1111; det_ready = 1'b1;
    tick();
    ch_clr = '0; det_ready = 1'b0; bit_valid = 4'b0100;
    for (int j = 0; j < 8; j++) begin
      bit_in = {1'b0, pat_v[7-j], 2'b00};
      tick();
    end
    check("pre_rst_det", int'(det_valid), 1);
    check("pre_rst_ch", int'(det_ch), 2);
    bit_valid = 4'b1111; det_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_det_valid", int'(det_valid), 0);
    check("arst_det_ch", int'(det_ch), 0);
    check("arst_bit_ready", int'(bit_ready), 0);
    check("arst_hit_cnt", int'(hit_cnt), 0);
    tick(); tick();
    bit_valid = 4'b0010;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bit_in = {2'b00, pat_v[7-j], 1'b0};
      tick();
    end
    check("post_rst_det", int'(det_valid), 1);
    check("post_rst_ch", int'(det_ch), 1);
    bit_valid = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "timeout");
  end
endmodule
